cmd_uart_tx: RTL and testbench
==============================

CMD_UART_TX -- requirements
Module: cmd_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417: clk cycles per UART bit (100 MHz / 9600 baud).
REQ-002 Parameter REFRESH_CYCLES, default 1_000_000: maximum idle gap between frames (10 ms).
REQ-003 clk  input  1  system clock, 100 MHz, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cmd  input  4  motion command {right, left, backward, forward}, bit3..bit0, same clock domain.
REQ-006 power_now  input  1  1 = car powered off, 0 = powered on.
REQ-007 tx  output  1  UART serial line to the car simulator, idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress.
REQ-009 tx_done  output  1  one-cycle pulse on the last cycle of a stop bit.

Function
REQ-010 Frame SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-011 Data byte SHALL be {3'b000, power_now, c[3:0]}; c = cmd when power_now = 0, c = 4'b0000 when power_now = 1.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP; any unused encoding returns to IDLE with tx = 1.
REQ-013 In IDLE the block SHALL start a frame when the candidate byte differs from last_sent, when pending is set, or when the refresh counter reaches REFRESH_CYCLES-1.
REQ-014 On frame start the candidate byte SHALL be latched into a shift register and last_sent, pending cleared, and the refresh counter zeroed; tx drops to 0 on the next cycle.
REQ-015 Latency from a cmd change in IDLE to the falling edge of tx SHALL be exactly 2 clk cycles.
REQ-016 Changes to cmd or power_now during a frame SHALL NOT alter the frame in flight.
REQ-017 After STOP the block SHALL spend at least one cycle in IDLE, then re-evaluate REQ-013; intermediate values during a frame are coalesced and only the current value is sent.
REQ-018 The refresh counter SHALL count only in IDLE, saturate at REFRESH_CYCLES-1, and never wrap.
REQ-019 Change and refresh expiring in the same cycle SHALL produce exactly one frame.
REQ-020 tx_busy SHALL be high from the first START cycle through the last STOP cycle inclusive.
REQ-021 The bit counter SHALL be 3 bits and move to STOP after bit index 7; the baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, reloading at CLKS_PER_BIT-1.

Reset
REQ-022 While rst = 0: tx = 1, tx_busy = 0, tx_done = 0, state = IDLE, all counters = 0, last_sent = 8'h00, pending = 1.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately (tx = 1 asynchronously); no partial frame resumes.
REQ-024 Because pending = 1, the first frame SHALL start within 2 cycles of rst release, whatever the inputs.

Structure
REQ-025 The shared package SHALL hold the state encoding, the byte field positions (CMD_LSB = 0, PWR_BIT = 4), and the default CLKS_PER_BIT and REFRESH_CYCLES.
REQ-026 Bit timing SHALL be a sub-module cmd_tx_baud: a counter with enable that emits a one-cycle bit_tick every CLKS_PER_BIT cycles and restarts on frame start.
REQ-027 All outputs SHALL be registered.

Verification
(All scenarios use CLKS_PER_BIT = 4 and REFRESH_CYCLES = 100.)
REQ-028 Release rst with cmd = 4'b0001 and power_now = 0 -> one frame with byte 8'h01; tx low 2 cycles after release; tx_done pulse after 40 frame cycles.
REQ-029 In IDLE, set cmd = 4'b1001 -> byte 8'h09, tx falls 2 cycles later, bits sampled mid-bit read 1,0,0,1,0,0,0,0.
REQ-030 Set power_now = 1 with cmd = 4'b0110 -> byte 8'h10.
REQ-031 Change cmd 0001 -> 0010 -> 0100 during one frame -> the frame in flight is unchanged; exactly one follow-up frame 8'h04 after at least 1 idle cycle.
REQ-032 Hold inputs constant -> a repeat frame starts every 100 idle cycles; a change landing on the expiry cycle gives exactly one frame.
REQ-033 Assert rst during data bit 3 -> tx = 1 with no clock edge; after release, a fresh frame of the current byte starts.

Source files
------------

// File: rtl/cmd_uart_tx_pkg.sv
// Shared definitions for the command UART transmitter.
//   - tx_state_t : frame state encoding (IDLE, START, DATA, STOP)
//   - CMD_W      : width of the motion command field
//   - CMD_LSB / PWR_BIT : position of the command nibble and power flag in the byte
//   - DEFAULT_*  : default bit period and refresh interval (100 MHz clock, 9600 baud, 10 ms)
//   - make_byte  : builds the byte to transmit from the live command and power inputs
package cmd_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int CMD_W   = 4;
    localparam int CMD_LSB = 0;
    localparam int PWR_BIT = 4;

    localparam int DEFAULT_CLKS_PER_BIT   = 10417;
    localparam int DEFAULT_REFRESH_CYCLES = 1_000_000;

    // A powered-off car must not see a motion command, so the nibble is
    // forced to zero whenever the power flag is set.
    function automatic logic [7:0] make_byte(input logic [CMD_W-1:0] cmd,
                                             input logic             power_now);
        logic [7:0] b;
        b = 8'h00;
        b[PWR_BIT] = power_now;
        if (!power_now) begin
            b[CMD_LSB +: CMD_W] = cmd;
        end
        return b;
    endfunction

endpackage

// File: rtl/cmd_uart_tx_if.sv
// Command/serial bundle of the command UART transmitter.
//   cmd       : motion command {right, left, backward, forward}
//   power_now : 1 = car powered off, 0 = powered on
//   tx        : UART serial line, idle high
//   tx_busy   : high while a frame is on the line
//   tx_done   : one-cycle pulse on the last cycle of a stop bit
// master drives the command side, slave is the transmitter.
interface cmd_uart_tx_if;
    import cmd_uart_tx_pkg::*;

    logic [CMD_W-1:0] cmd;
    logic             power_now;
    logic             tx;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output cmd,
        output power_now,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  cmd,
        input  power_now,
        output tx,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/cmd_tx_baud.sv
// Bit-period timer for the command UART transmitter.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   en       : count while a frame is in progress
//   restart  : realign the bit period to the start of a new frame
//   bit_tick : one-cycle pulse on the last cycle of every bit period
module cmd_tx_baud
    import cmd_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic bit_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (restart) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    // Decoded from a register, so the tick is glitch-free for the FSM.
    assign bit_tick = en && (count_reg == LAST);

endmodule

// File: rtl/cmd_uart_tx.sv
// Command UART transmitter: sends {3'b000, power_now, cmd} as 8N1 frames
// whenever the byte changes, after reset, and at least once per refresh
// interval while the inputs are constant.
//   clk : system clock
//   rst : asynchronous active-low reset (aborts any frame, tx forced high)
//   bus : cmd_uart_tx_if.slave (cmd, power_now in; tx, tx_busy, tx_done out)
// Parameters: CLKS_PER_BIT (clocks per bit), REFRESH_CYCLES (max idle gap).
module cmd_uart_tx
    import cmd_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int REFRESH_CYCLES = DEFAULT_REFRESH_CYCLES
) (
    input  logic          clk,
    input  logic          rst,
    cmd_uart_tx_if.slave  bus
);

    localparam int            RW          = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_CYCLES - 1);

    tx_state_t     state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [RW-1:0] refresh_cnt_reg;
    logic [7:0]    last_sent_reg;
    logic [7:0]    shift_reg;
    logic          pending_reg;
    logic          tx_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [7:0]    candidate;
    logic          refresh_expired;
    logic          start_frame;
    logic          bit_tick;

    assign candidate       = make_byte(bus.cmd, bus.power_now);
    assign refresh_expired = (refresh_cnt_reg == REFRESH_MAX);
    // Change, pending and refresh all fold into one start condition, so
    // coincident triggers can only ever launch a single frame.
    assign start_frame     = (state_reg == IDLE) &&
                             ((candidate != last_sent_reg) || pending_reg || refresh_expired);

    cmd_tx_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg != IDLE),
        .restart  (start_frame),
        .bit_tick (bit_tick)
    );

    // The line outputs are registered from the current state, so tx, tx_busy
    // and tx_done all trail the state register by exactly one cycle and stay
    // mutually aligned: the START state entered on the trigger edge appears
    // on tx one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            refresh_cnt_reg <= '0;
            last_sent_reg   <= 8'h00;
            shift_reg       <= 8'h00;
            pending_reg     <= 1'b1;
            tx_reg          <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            tx_reg   <= 1'b1;
            busy_reg <= (state_reg != IDLE);
            done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start_frame) begin
                        shift_reg       <= candidate;
                        last_sent_reg   <= candidate;
                        pending_reg     <= 1'b0;
                        refresh_cnt_reg <= '0;
                        bit_cnt_reg     <= '0;
                        state_reg       <= START;
                    end else if (!refresh_expired) begin
                        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
                    end
                end

                START: begin
                    tx_reg <= 1'b0;
                    if (bit_tick) begin
                        state_reg <= DATA;
                    end
                end

                DATA: begin
                    tx_reg <= shift_reg[0];
                    if (bit_tick) begin
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end
                end

                STOP: begin
                    tx_reg <= 1'b1;
                    if (bit_tick) begin
                        // Lands on the final stop-bit cycle of tx.
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx      = tx_reg;
    assign bus.tx_busy = busy_reg;
    assign bus.tx_done = done_reg;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Self-checking bench for cmd_uart_tx with CLKS_PER_BIT = 4, REFRESH_CYCLES = 100.
// Expected bytes are queued when stimulus is applied; a line monitor decodes
// each frame from tx and compares it against the head of the queue.
module tb_cmd_uart_tx;
    import cmd_uart_tx_pkg::*;

    localparam int CPB = 4;
    localparam int REF = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;

    cmd_uart_tx_if bus ();

    cmd_uart_tx #(
        .CLKS_PER_BIT   (CPB),
        .REFRESH_CYCLES (REF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    int starts_seen = 0;
    int frames_done = 0;
    int aborted     = 0;
    int fall_at[32];
    int done_at[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int n, input string tag);
        int t = 0;
        while (frames_done < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(frames_done >= n), 1);
    endtask

    task automatic wait_starts(input int n, input string tag);
        int t = 0;
        while (starts_seen < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(starts_seen >= n), 1);
    endtask

    // Line monitor: offsets are counted in cycles from the first low cycle.
    // Mid-bit samples at 2 + 4*k; last stop cycle at 39; first idle at 40.
    initial begin : monitor
        logic [7:0] data;
        logic [7:0] exp_b;
        int off;
        int tgt;
        int idx;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && bus.tx === 1'b0) begin
                starts_seen++;
                idx = starts_seen;
                fall_at[idx] = cyc;
                check("busy_first_start_cycle", 32'(bus.tx_busy), 1);
                off  = 0;
                ab   = 1'b0;
                data = 8'h00;
                for (int k = 0; k < 12; k++) begin
                    tgt = (k < 10) ? 2 + 4 * k : 29 + k;
                    while (off < tgt && rst === 1'b1) begin
                        @(negedge clk);
                        off++;
                    end
                    if (rst !== 1'b1) begin
                        ab = 1'b1;
                        break;
                    end
                    if (k == 0) begin
                        check("start_bit_mid", 32'(bus.tx), 0);
                    end else if (k <= 8) begin
                        data[k-1] = bus.tx;
                    end else if (k == 9) begin
                        check("stop_bit_mid", 32'(bus.tx), 1);
                        check("tx_done_early", 32'(bus.tx_done), 0);
                    end else if (k == 10) begin
                        done_at[idx] = cyc;
                        check("tx_done_last_stop_cycle", 32'(bus.tx_done), 1);
                        check("busy_last_stop_cycle", 32'(bus.tx_busy), 1);
                        check("tx_high_last_stop_cycle", 32'(bus.tx), 1);
                    end else begin
                        check("tx_done_one_cycle", 32'(bus.tx_done), 0);
                        check("busy_low_after_frame", 32'(bus.tx_busy), 0);
                    end
                end
                if (ab) begin
                    aborted++;
                    if (sb.size() > 0) void'(sb.pop_front());
                    $display("frame %0d: aborted by reset at offset %0d", idx, off);
                end else begin
                    check("frame_expected", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_b = sb.pop_front();
                        check("frame_byte", 32'(data), 32'(exp_b));
                        $display("frame %0d: fall@%0d byte=%02h expected=%02h", idx, fall_at[idx], data, exp_b);
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int c0;
        int d;

        // Reset values, then first frame forced by pending.
        bus.cmd       = 4'b0001;
        bus.power_now = 1'b0;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(bus.tx), 1);
        check("reset_busy", 32'(bus.tx_busy), 0);
        check("reset_done", 32'(bus.tx_done), 0);
        sb.push_back(8'h01);
        rst = 1'b1;
        c0  = cyc;
        wait_done(1, "wait_frame1");
        check("rst_release_latency", 32'(fall_at[1] - c0), 2);

        // Command change in IDLE.
        bus.cmd = 4'b1001;
        sb.push_back(8'h09);
        c0 = cyc;
        wait_done(2, "wait_frame2");
        check("cmd_change_latency", 32'(fall_at[2] - c0), 2);

        // Powered off: command nibble masked.
        bus.power_now = 1'b1;
        bus.cmd       = 4'b0110;
        sb.push_back(8'h10);
        c0 = cyc;
        wait_done(3, "wait_frame3");
        check("power_off_latency", 32'(fall_at[3] - c0), 2);

        // Changes during a frame coalesce into one follow-up frame.
        bus.power_now = 1'b0;
        bus.cmd       = 4'b0001;
        sb.push_back(8'h01);
        c0 = cyc;
        wait_starts(4, "wait_start4");
        repeat (8) @(negedge clk);
        bus.cmd = 4'b0010;
        repeat (8) @(negedge clk);
        bus.cmd = 4'b0100;
        sb.push_back(8'h04);
        wait_done(5, "wait_frame5");
        check("frame4_latency", 32'(fall_at[4] - c0), 2);
        check("followup_gap", 32'(fall_at[5] - done_at[4]), 2);
        check("followup_count", 32'(starts_seen), 5);

        // Constant inputs: refresh frame after 100 idle cycles.
        sb.push_back(8'h04);
        wait_done(6, "wait_frame6");
        check("refresh_gap", 32'(fall_at[6] - done_at[5]), 101);

        // Change landing on the refresh expiry cycle.
        d = done_at[6];
        while (cyc < d + 99) @(negedge clk);
        bus.cmd = 4'b1000;
        sb.push_back(8'h08);
        wait_done(7, "wait_frame7");
        check("change_on_expiry_gap", 32'(fall_at[7] - done_at[6]), 101);
        repeat (60) @(negedge clk);
        check("single_frame_on_expiry", 32'(starts_seen), 7);

        // Reset during data bit 3 aborts; a fresh frame follows release.
        bus.cmd = 4'b0011;
        sb.push_back(8'h03);
        c0 = cyc;
        wait_starts(8, "wait_start8");
        check("frame8_latency", 32'(fall_at[8] - c0), 2);
        d = fall_at[8];
        while (cyc < d + 17) @(negedge clk);
        check("tx_data_bit3_before_abort", 32'(bus.tx), 0);
        rst = 1'b0;
        #1;
        check("abort_tx_async", 32'(bus.tx), 1);
        check("abort_busy_async", 32'(bus.tx_busy), 0);
        check("abort_done_async", 32'(bus.tx_done), 0);
        repeat (5) @(negedge clk);
        check("aborted_frames", 32'(aborted), 1);
        sb.push_back(8'h03);
        rst = 1'b1;
        c0  = cyc;
        wait_done(8, "wait_frame9");
        check("restart_latency", 32'(fall_at[9] - c0), 2);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 0);
        check("total_starts", 32'(starts_seen), 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
